dz_tx_scanner: RTL and testbench

DZ11 transmit scanner. Round-robin scan of the eight asynchronous lines, selecting the next line whose Transmit Control Register line-enable bit is set and whose UART transmit buffer is empty. Presents that line to the CSR as TRDY/TLINE and steers the next Transmit Data Register write into that line's UART. Sits between the TCR/CSR register file and the eight per-line UART transmitters inside the DZ11.

---
 rtl/dz_tx_scanner.sv | 104 ++++++++++
 tb/tb_dz_tx_scanner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dz_tx_scanner.sv
// DZ11 transmit scanner: round-robin search for a line that is enabled and has an empty UART,
// presents it as TRDY/TLINE and steers the next low-byte TDR write into that line's UART.
module dz_tx_scanner #(
  parameter int unsigned SCANDIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        devRESET,
  input  logic        csrCLR,
  input  logic        csrMSE,
  input  logic [7:0]  tcrLIN,
  input  logic [7:0]  txEMPTY,
  input  logic        tdrWRITE,
  input  logic        devLOBYTE,
  input  logic [35:0] dzDATAI,
  output logic        csrTRDY,
  output logic [2:0]  csrTLINE,
  output logic [7:0]  txLOAD,
  output logic [7:0]  txDATA
);

  localparam logic [1:0] StScan  = 2'd0;
  localparam logic [1:0] StReady = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;

  localparam logic [7:0] CntLast = 8'(SCANDIV - 1);

  logic [1:0] stateQ, stateD;
  logic [2:0] ptrQ, ptrD;
  logic [7:0] cntQ, cntD;
  logic [2:0] tlineQ, tlineD;
  logic [7:0] tdataQ, tdataD;
  logic       clear;

  assign clear = !rst || devRESET || csrCLR;

  always_comb begin
    stateD = stateQ;
    ptrD   = ptrQ;
    cntD   = cntQ;
    tlineD = tlineQ;
    tdataD = tdataQ;
    case (stateQ)
      StScan: begin
        if (!csrMSE) begin
          cntD = 8'd0;
        end else if (cntQ == CntLast) begin
          cntD = 8'd0;
          if (tcrLIN[ptrQ] && txEMPTY[ptrQ]) begin
            stateD = StReady;
            tlineD = ptrQ;
          end else begin
            ptrD = ptrQ + 3'd1;
          end
        end else begin
          cntD = cntQ + 8'd1;
        end
      end
      StReady: begin
        // Priority: MSE drop, then line disable, then a low-byte write.
        if (!csrMSE) begin
          stateD = StScan;
        end else if (!tcrLIN[tlineQ]) begin
          stateD = StScan;
          ptrD   = tlineQ + 3'd1;
        end else if (tdrWRITE && devLOBYTE) begin
          stateD = StLoad;
          tdataD = dzDATAI[7:0];
          ptrD   = tlineQ + 3'd1;
        end
      end
      StLoad: begin
        stateD = StScan;
        cntD   = 8'd0;
      end
      default: begin
        stateD = StScan;
        cntD   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      stateQ <= StScan;
      ptrQ   <= 3'd0;
      cntQ   <= 8'd0;
      tlineQ <= 3'd0;
      tdataQ <= 8'd0;
    end else begin
      stateQ <= stateD;
      ptrQ   <= ptrD;
      cntQ   <= cntD;
      tlineQ <= tlineD;
      tdataQ <= tdataD;
    end
  end

  assign csrTRDY  = (stateQ == StReady);
  assign csrTLINE = tlineQ;
  assign txLOAD   = (stateQ == StLoad) ? (8'd1 << tlineQ) : 8'd0;
  assign txDATA   = tdataQ;

endmodule

// File: tb/tb_dz_tx_scanner.sv
// Directed self-checking bench for dz_tx_scanner with SCANDIV=4.
module tb_dz_tx_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        devRESET;
  logic        csrCLR;
  logic        csrMSE;
  logic [7:0]  tcrLIN;
  logic [7:0]  txEMPTY;
  logic        tdrWRITE;
  logic        devLOBYTE;
  logic [35:0] dzDATAI;
  logic        csrTRDY;
  logic [2:0]  csrTLINE;
  logic [7:0]  txLOAD;
  logic [7:0]  txDATA;

  int testsRun = 0;
  int testsFailed = 0;

  dz_tx_scanner #(.SCANDIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .devRESET (devRESET),
    .csrCLR   (csrCLR),
    .csrMSE   (csrMSE),
    .tcrLIN   (tcrLIN),
    .txEMPTY  (txEMPTY),
    .tdrWRITE (tdrWRITE),
    .devLOBYTE(devLOBYTE),
    .dzDATAI  (dzDATAI),
    .csrTRDY  (csrTRDY),
    .csrTLINE (csrTLINE),
    .txLOAD   (txLOAD),
    .txDATA   (txDATA)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one active edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    devRESET = 1'b0;
    csrCLR = 1'b0;
    csrMSE = 1'b0;
    tcrLIN = 8'h00;
    txEMPTY = 8'hFF;
    tdrWRITE = 1'b0;
    devLOBYTE = 1'b0;
    dzDATAI = 36'h0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Counts edges until TRDY rises (bounded) and checks the count.
  task automatic waitTrdy(input string tag, input int expEdges);
    int n;
    n = 0;
    while (!csrTRDY && n < 100) begin
      tick();
      n++;
    end
    checkEq(tag, n, expEdges);
  endtask

  initial begin
    int trdyHits;
    int loadHits;
    logic [2:0] p28, p31, p32, p36;
    int order[$];
    int reraise[8];

    // Reset state, then idle scanning with no line enabled.
    applyReset();
    checkEq("reset trdy", 32'(csrTRDY), 0);
    checkEq("reset tline", 32'(csrTLINE), 0);
    checkEq("reset txload", 32'(txLOAD), 0);
    checkEq("reset txdata", 32'(txDATA), 0);
    checkEq("reset ptr", 32'(dut.ptrQ), 0);
    csrMSE = 1'b1;
    trdyHits = 0;
    p28 = 3'd0; p31 = 3'd0; p32 = 3'd0; p36 = 3'd0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (csrTRDY) trdyHits++;
      if (n == 28) p28 = dut.ptrQ;
      if (n == 31) p31 = dut.ptrQ;
      if (n == 32) p32 = dut.ptrQ;
      if (n == 36) p36 = dut.ptrQ;
    end
    checkEq("idle no trdy", trdyHits, 0);
    checkEq("idle ptr e28", 32'(p28), 7);
    checkEq("idle ptr e31", 32'(p31), 7);
    checkEq("idle ptr e32", 32'(p32), 0);
    checkEq("idle ptr e36", 32'(p36), 1);

    // Line 5 only: TRDY at edge 24, then load 'A'.
    applyReset();
    csrMSE = 1'b1;
    tcrLIN = 8'h20;
    waitTrdy("line5 latency", 24);
    checkEq("line5 tline", 32'(csrTLINE), 5);
    tdrWRITE = 1'b1;
    devLOBYTE = 1'b1;
    dzDATAI = 36'h041;
    tick();
    tdrWRITE = 1'b0;
    checkEq("line5 txload", 32'(txLOAD), 32'h20);
    checkEq("line5 txdata", 32'(txDATA), 32'h41);
    checkEq("line5 trdy fell", 32'(csrTRDY), 0);
    tick();
    checkEq("line5 load one cycle", 32'(txLOAD), 0);
    checkEq("line5 txdata holds", 32'(txDATA), 32'h41);

    // Fairness: all lines enabled and empty, UART model drops/re-raises txEMPTY.
    applyReset();
    csrMSE = 1'b1;
    tcrLIN = 8'hFF;
    for (int i = 0; i < 8; i++) reraise[i] = -1;
    for (int cyc = 1; cyc <= 400 && order.size() < 9; cyc++) begin
      tick();
      tdrWRITE = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (reraise[i] == cyc) txEMPTY[i] = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        if (txLOAD[i]) begin
          order.push_back(i);
          checkEq("fair txdata", 32'(txDATA), 32'h30 + i);
          txEMPTY[i] = 1'b0;
          reraise[i] = cyc + 200;
        end
      end
      if (csrTRDY) begin
        tdrWRITE = 1'b1;
        devLOBYTE = 1'b1;
        dzDATAI = 36'h30 + 36'(csrTLINE);
      end
    end
    tdrWRITE = 1'b0;
    checkEq("fair load count", order.size(), 9);
    for (int k = 0; k < order.size(); k++) checkEq("fair order", order[k], k % 8);

    // Disable of line 3 coincident with a write: disable wins, next candidate is line 4.
    applyReset();
    csrMSE = 1'b1;
    tcrLIN = 8'h08;
    waitTrdy("line3 latency", 16);
    checkEq("line3 tline", 32'(csrTLINE), 3);
    tcrLIN = 8'h10;
    tdrWRITE = 1'b1;
    devLOBYTE = 1'b1;
    dzDATAI = 36'h0AA;
    loadHits = 0;
    tick();
    tdrWRITE = 1'b0;
    checkEq("disable trdy", 32'(csrTRDY), 0);
    for (int n = 0; n < 3; n++) begin
      if (txLOAD != 8'h00) loadHits++;
      tick();
    end
    checkEq("disable no load", loadHits, 0);
    checkEq("disable trdy e3", 32'(csrTRDY), 0);
    tick();
    checkEq("next line4 trdy", 32'(csrTRDY), 1);
    checkEq("next line4 tline", 32'(csrTLINE), 4);

    // High-byte-only write ignored on line 6, then CSR[CLR].
    applyReset();
    csrMSE = 1'b1;
    tcrLIN = 8'h40;
    waitTrdy("line6 latency", 28);
    tdrWRITE = 1'b1;
    devLOBYTE = 1'b0;
    dzDATAI = 36'h077;
    tick();
    tdrWRITE = 1'b0;
    checkEq("hibyte no load", 32'(txLOAD), 0);
    checkEq("hibyte trdy stays", 32'(csrTRDY), 1);
    checkEq("hibyte txdata", 32'(txDATA), 0);
    csrCLR = 1'b1;
    tick();
    csrCLR = 1'b0;
    checkEq("clr trdy", 32'(csrTRDY), 0);
    checkEq("clr tline", 32'(csrTLINE), 0);
    checkEq("clr ptr", 32'(dut.ptrQ), 0);

    // Reset during LOAD on line 2 drops the character; scanning restarts at line 0.
    applyReset();
    csrMSE = 1'b1;
    tcrLIN = 8'h04;
    waitTrdy("line2 latency", 12);
    tdrWRITE = 1'b1;
    devLOBYTE = 1'b1;
    dzDATAI = 36'h055;
    tick();
    tdrWRITE = 1'b0;
    checkEq("line2 txload", 32'(txLOAD), 32'h04);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkEq("rst in load txload", 32'(txLOAD), 0);
    checkEq("rst in load txdata", 32'(txDATA), 0);
    checkEq("rst in load trdy", 32'(csrTRDY), 0);
    checkEq("rst in load tline", 32'(csrTLINE), 0);
    tcrLIN = 8'h05;
    waitTrdy("restart latency", 4);
    checkEq("restart tline", 32'(csrTLINE), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
